// File: rtl/ram_fill_pkg.sv
// ram_fill shared definitions: frame geometry defaults and FSM encoding.
// Imported by the interface, the address generator and the top.
package ram_fill_pkg;

    localparam int DEF_FRAME_W = 160;
    localparam int DEF_FRAME_H = 120;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ram_fill_if.sv
// Sample stream in plus frame RAM write port out.
// master = pixel source / RAM side, slave = the fill controller.
interface ram_fill_if
    import ram_fill_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

endinterface

// File: rtl/ram_fill_addr_gen.sv
// Raster position counters: column, row and linear RAM address.
// All three move together on advance and wrap to 0 after the last pixel.
module ram_fill_addr_gen
    import ram_fill_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COL_W   = $clog2(FRAME_W),
    parameter int ROW_W   = $clog2(FRAME_H)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    logic last_col;

    assign last_col   = (col == COL_W'(FRAME_W - 1));
    assign last_pixel = last_col && (row == ROW_W'(FRAME_H - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            if (last_pixel) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else if (last_col) begin
                col  <= '0;
                row  <= row + ROW_W'(1);
                addr <= addr + ADDR_W'(1);
            end else begin
                col  <= col + COL_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_fill.sv
// Framebuffer fill controller: writes an accepted pixel stream into frame
// RAM in raster order, one registered write per accepted sample.
module ram_fill
    import ram_fill_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COL_W   = $clog2(FRAME_W),
    parameter int ROW_W   = $clog2(FRAME_H)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    ram_fill_if.slave        bus,
    output logic             busy,
    output logic             frame_done,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row
);

    if ((2 ** ADDR_W) < (FRAME_W * FRAME_H)) begin : g_addr_chk
        $error("ADDR_W too small for FRAME_W*FRAME_H");
    end

    state_t state;
    state_t state_nx;

    logic              clear;
    logic              accept;
    logic              last_pixel;
    logic [ADDR_W-1:0] lin_addr;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;

    assign bus.sample_ready = (state == FILL) && !abort;
    assign accept = bus.sample_valid && bus.sample_ready;
    assign busy   = (state == FILL);

    ram_fill_addr_gen #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .ADDR_W  (ADDR_W),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_addr_gen (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (accept),
        .col        (cur_col),
        .row        (cur_row),
        .addr       (lin_addr),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FILL;
                    clear    = 1'b1;
                end
            end
            FILL: begin
                if (abort) begin
                    state_nx = IDLE;
                    clear    = 1'b1;
                end else if (accept && last_pixel) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // DONE coincides with the last write cycle, so the pulse lands one later.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= accept;
            done_q <= (state == DONE);
            if (accept) begin
                addr_q  <= lin_addr;
                wdata_q <= bus.sample_data;
            end
        end
    end

    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_ram_fill.sv
// Randomised and directed bench for ram_fill on a 4x3 frame, checked every
// cycle against a pixel-index model of the fill.
module tb_ram_fill;

    localparam int FW   = 4;
    localparam int FH   = 3;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int NPIX = FW * FH;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [1:0] cur_col;
    logic [1:0] cur_row;

    ram_fill_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_fill #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .cur_col    (cur_col),
        .cur_row    (cur_row)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 filling, 2 frame complete; pos is pixel index.
    bit          m_ok    = 0;
    int          m_phase = 0;
    int          m_pos   = 0;
    bit          m_pend  = 0;
    bit          m_acc;
    bit          e_we    = 0;
    int          e_addr  = 0;
    int          e_data  = 0;
    bit          e_done  = 0;
    int          wcount  = 0;
    int          dcount  = 0;

    always @(posedge clk_in) begin
        if (m_ok)
            chk("sample_ready", {31'b0, bus.sample_ready},
                {31'b0, (m_phase == 1) && !abort});
        if (!rst_n) begin
            m_ok    = 1;
            m_phase = 0;
            m_pos   = 0;
            m_pend  = 0;
            e_we    = 0;
            e_addr  = 0;
            e_data  = 0;
            e_done  = 0;
        end else begin
            e_done = m_pend;
            m_pend = 0;
            m_acc  = (m_phase == 1) && !abort && bus.sample_valid;
            e_we   = m_acc;
            if (m_acc) begin
                e_addr = m_pos;
                e_data = int'(bus.sample_data);
            end
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_pos   = 0;
                end
                1: if (abort) begin
                    m_phase = 0;
                    m_pos   = 0;
                end else if (m_acc) begin
                    if (m_pos == NPIX - 1) begin
                        m_phase = 2;
                        m_pos   = 0;
                        m_pend  = 1;
                    end else begin
                        m_pos++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        if (m_ok) begin
            chk("ram_we", {31'b0, bus.ram_we}, {31'b0, e_we});
            chk("ram_addr", 32'(bus.ram_addr), e_addr);
            chk("ram_wdata", 32'(bus.ram_wdata), e_data);
            chk("frame_done", {31'b0, frame_done}, {31'b0, e_done});
            chk("busy", {31'b0, busy}, {31'b0, m_phase == 1});
            chk("cur_col", 32'(cur_col), m_pos % FW);
            chk("cur_row", 32'(cur_row), m_pos / FW);
            wcount += int'(bus.ram_we);
            dcount += int'(frame_done);
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit toggle, input int base);
        int sent = 0;
        int k    = 0;
        while (sent < n) begin
            bus.sample_valid = toggle ? (k % 2 == 0) : 1'b1;
            bus.sample_data  = DW'(base + sent);
            tick();
            if (bus.sample_valid) sent++;
            k++;
        end
        bus.sample_valid = 1'b0;
    endtask

    int w0;
    int d0;

    initial begin
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'hA5;
        start = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ram_we", {31'b0, bus.ram_we}, 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {31'b0, bus.sample_ready}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        bus.sample_valid = 1'b0;
        tick();

        w0 = wcount; d0 = dcount;
        pulse_start();
        send(NPIX, 1'b0, 'h10);
        chk("s2_last_we", {31'b0, bus.ram_we}, 1);
        chk("s2_last_addr", 32'(bus.ram_addr), 11);
        chk("s2_last_data", 32'(bus.ram_wdata), 'h1B);
        tick();
        chk("s2_done", {31'b0, frame_done}, 1);
        chk("s2_col", 32'(cur_col), 0);
        repeat (2) tick();
        chk("s2_writes", wcount - w0, 12);
        chk("s2_dones", dcount - d0, 1);

        w0 = wcount; d0 = dcount;
        pulse_start();
        send(NPIX, 1'b1, 'h10);
        repeat (3) tick();
        chk("s3_writes", wcount - w0, 12);
        chk("s3_dones", dcount - d0, 1);

        w0 = wcount; d0 = dcount;
        pulse_start();
        send(5, 1'b0, 'h40);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'h45;
        abort = 1'b1;
        #1;
        chk("s4_abort_ready", {31'b0, bus.sample_ready}, 0);
        tick();
        abort = 1'b0;
        bus.sample_valid = 1'b0;
        chk("s4_idle", {31'b0, busy}, 0);
        repeat (2) tick();
        chk("s4_writes", wcount - w0, 5);
        chk("s4_dones", dcount - d0, 0);
        chk("s4_last_addr", 32'(bus.ram_addr), 4);

        w0 = wcount; d0 = dcount;
        pulse_start();
        send(3, 1'b0, 'h50);
        pulse_start();
        send(9, 1'b0, 'h53);
        pulse_start();
        chk("s5_done_start_ignored", {31'b0, busy}, 0);
        repeat (2) tick();
        chk("s5_writes", wcount - w0, 12);
        chk("s5_dones", dcount - d0, 1);

        w0 = wcount; d0 = dcount;
        pulse_start();
        send(7, 1'b0, 'h60);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulse_start();
        send(NPIX, 1'b0, 'h70);
        repeat (3) tick();
        chk("s6_writes", wcount - w0, 19);
        chk("s6_dones", dcount - d0, 1);

        repeat (3000) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 24) == 0);
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample_data  = DW'($urandom);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
